// File: rtl/alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_sequencer_if
// Handshake / control bundle between the CPU control unit plus the ALU
// datapath (master side) and the ALU micro-sequencer (slave side).
//   start     : operation request, honoured only while the sequencer is idle
//   op        : requested operation code
//   q0        : datapath Q[0], steers the shift-add multiply
//   a_sign    : datapath A msb after the trial subtract, steers the divide
//   div_zero  : divisor operand is zero, looked at in the LOAD cycle
//   alu_op    : operation latched at start, selects the single-pass function
//   c         : datapath control strobes c[7:0]
//   busy      : sequencer not idle
//   ack       : one-cycle completion pulse
//   err       : qualifies ack when the operation was aborted
// ---------------------------------------------------------------------------
interface alu_sequencer_if;
   logic       start;
   logic [2:0] op;
   logic       q0;
   logic       a_sign;
   logic       div_zero;
   logic [2:0] alu_op;
   logic [7:0] c;
   logic       busy;
   logic       ack;
   logic       err;

   modport master (
      output start, op, q0, a_sign, div_zero,
      input  alu_op, c, busy, ack, err
   );

   modport slave (
      input  start, op, q0, a_sign, div_zero,
      output alu_op, c, busy, ack, err
   );
endinterface

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Multi-cycle ALU controller. Takes start/op from the CPU control unit and
// walks the ALU datapath through single-pass ADD/SUB/AND/OR/XOR, shift-add
// MUL and restoring DIV, finishing every operation with a one-cycle ack.
// Ports:
//   clk    : system clock, rising edge
//   rst_b  : synchronous active-low reset
//   bus    : alu_sequencer_if.slave (start/op/q0/a_sign/div_zero in,
//            alu_op/c/busy/ack/err out)
// Strobes: c0 LOAD | c1 A+=M | c2 A-=M | c3 A=Q alu_op M | c4 {A,Q}>>1 |
//          c5 {A,Q}<<1 | c6 Q[0]=1 | c7 drive result
// ---------------------------------------------------------------------------
module alu_sequencer #(
   parameter int N = 16
) (
   input  logic             clk,
   input  logic             rst_b,
   alu_sequencer_if.slave   bus
);

   localparam int            CW       = $clog2(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_DIV = 3'b110;
   localparam logic [2:0] OP_RSV = 3'b111;

   typedef enum logic [13:0] {
      S_IDLE      = 14'h0001,
      S_LOAD      = 14'h0002,
      S_EXEC      = 14'h0004,
      S_M_TEST    = 14'h0008,
      S_M_ADD     = 14'h0010,
      S_M_SHIFT   = 14'h0020,
      S_D_SHIFT   = 14'h0040,
      S_D_SUB     = 14'h0080,
      S_D_CHK     = 14'h0100,
      S_D_RESTORE = 14'h0200,
      S_D_SET     = 14'h0400,
      S_OUT       = 14'h0800,
      S_DONE      = 14'h1000,
      S_ERR       = 14'h2000
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic [2:0]    alu_op_q;
   logic [7:0]    c_q;
   logic          busy_q, ack_q, err_q;
   logic          cnt_last;

   // Loops exit on the last index rather than wrapping the counter.
   assign cnt_last = (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (bus.start) state_d = S_LOAD;
         S_LOAD: begin
            // Decisions use the latched opcode so late op changes are ignored.
            if (alu_op_q == OP_RSV || (alu_op_q == OP_DIV && bus.div_zero))
               state_d = S_ERR;
            else if (alu_op_q == OP_MUL)
               state_d = S_M_TEST;
            else if (alu_op_q == OP_DIV)
               state_d = S_D_SHIFT;
            else
               state_d = S_EXEC;
         end
         S_EXEC:      state_d = S_OUT;
         S_M_TEST:    state_d = bus.q0 ? S_M_ADD : S_M_SHIFT;
         S_M_ADD:     state_d = S_M_SHIFT;
         S_M_SHIFT:   state_d = cnt_last ? S_OUT : S_M_TEST;
         S_D_SHIFT:   state_d = S_D_SUB;
         S_D_SUB:     state_d = S_D_CHK;
         S_D_CHK:     state_d = bus.a_sign ? S_D_RESTORE : S_D_SET;
         S_D_RESTORE: state_d = cnt_last ? S_OUT : S_D_SHIFT;
         S_D_SET:     state_d = cnt_last ? S_OUT : S_D_SHIFT;
         S_OUT:       state_d = S_DONE;
         S_DONE:      state_d = S_IDLE;
         S_ERR:       state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so they are
   // glitch-free and line up exactly with the state they belong to.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         alu_op_q <= '0;
         c_q      <= '0;
         busy_q   <= 1'b0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;

         if (state_q == S_IDLE && bus.start)
            alu_op_q <= bus.op;

         if (state_q == S_LOAD)
            cnt_q <= '0;
         else if ((state_q == S_M_SHIFT || state_q == S_D_RESTORE ||
                   state_q == S_D_SET) && !cnt_last)
            cnt_q <= cnt_q + 1'b1;

         c_q <= {state_d == S_OUT,
                 state_d == S_D_SET,
                 state_d == S_D_SHIFT,
                 state_d == S_M_SHIFT,
                 state_d == S_EXEC,
                 state_d == S_D_SUB,
                 (state_d == S_M_ADD || state_d == S_D_RESTORE),
                 state_d == S_LOAD};
         busy_q <= (state_d != S_IDLE);
         ack_q  <= (state_d == S_DONE || state_d == S_ERR);
         err_q  <= (state_d == S_ERR);
      end
   end

   assign bus.alu_op = alu_op_q;
   assign bus.c      = c_q;
   assign bus.busy   = busy_q;
   assign bus.ack    = ack_q;
   assign bus.err    = err_q;

endmodule
